// File: rtl/ariane_dm_pkg.sv
// rtl/ariane_dm_pkg.sv - debug ROM addresses, dcsr.cause codes and hart debug states
package ariane_dm_pkg;

   localparam logic [63:0] HaltAddress      = 64'h800;
   localparam logic [63:0] ResumeAddress    = HaltAddress + 64'h4;
   localparam logic [63:0] ExceptionAddress = HaltAddress + 64'h8;

   localparam logic [2:0] CauseBreakpoint = 3'h1;
   localparam logic [2:0] CauseTrigger    = 3'h2;
   localparam logic [2:0] CauseRequest    = 3'h3;
   localparam logic [2:0] CauseSingleStep = 3'h4;

   typedef enum logic [1:0] {RUN, FLUSH, HALTED, STEP} dbg_state_e;

endpackage

// File: rtl/ariane_debug_hart_ctrl.sv
// rtl/ariane_debug_hart_ctrl.sv - hart-side debug halt/resume controller
module ariane_debug_hart_ctrl
   import ariane_dm_pkg::*;
#(
   parameter int unsigned XLEN   = 64,
   parameter logic [63:0] DmBase = 64'h0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            debug_req_i,
   input  logic            resumereq_i,
   input  logic            ebreak_i,
   input  logic            trigger_i,
   input  logic            commit_valid_i,
   input  logic [XLEN-1:0] commit_pc_i,
   input  logic [XLEN-1:0] next_pc_i,
   input  logic            step_i,
   input  logic            flush_done_i,
   input  logic            dret_i,
   input  logic            ex_in_debug_i,
   output logic            flush_o,
   output logic            redirect_valid_o,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic            debug_mode_o,
   output logic [XLEN-1:0] dpc_o,
   output logic [2:0]      cause_o
);

   localparam logic [XLEN-1:0] HaltPc      = XLEN'(DmBase + HaltAddress);
   localparam logic [XLEN-1:0] ResumePc    = XLEN'(DmBase + ResumeAddress);
   localparam logic [XLEN-1:0] ExceptionPc = XLEN'(DmBase + ExceptionAddress);

   dbg_state_e      state_q, state_d;
   logic            flush_q, flush_d;
   logic            redirect_valid_q, redirect_valid_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
   logic            debug_mode_q, debug_mode_d;
   logic [XLEN-1:0] dpc_q, dpc_d;
   logic [2:0]      cause_q, cause_d;
   logic            resume_pend_q, resume_pend_d;

   logic            halt_now;
   logic [XLEN-1:0] halt_dpc;
   logic [2:0]      halt_cause;
   logic            resume_now;

   // Commit-synchronous halt causes: trigger > ebreak > step completion.
   always_comb begin
      halt_now   = commit_valid_i & (trigger_i | ebreak_i | (state_q == STEP));
      halt_dpc   = next_pc_i;
      halt_cause = CauseSingleStep;
      if (commit_valid_i & trigger_i) begin
         halt_dpc   = commit_pc_i;
         halt_cause = CauseTrigger;
      end else if (commit_valid_i & ebreak_i) begin
         halt_dpc   = commit_pc_i;
         halt_cause = CauseBreakpoint;
      end
   end

   always_comb begin
      state_d          = state_q;
      flush_d          = flush_q;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = redirect_pc_q;
      debug_mode_d     = debug_mode_q;
      dpc_d            = dpc_q;
      cause_d          = cause_q;
      resume_pend_d    = resume_pend_q;
      resume_now       = resumereq_i | resume_pend_q;

      unique case (state_q)
         RUN, STEP: begin
            if (halt_now) begin
               dpc_d            = halt_dpc;
               cause_d          = halt_cause;
               redirect_valid_d = 1'b1;
               redirect_pc_d    = HaltPc;
               debug_mode_d     = 1'b1;
               state_d          = HALTED;
            end else if (debug_req_i) begin
               flush_d = 1'b1;
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (flush_done_i) begin
               flush_d          = 1'b0;
               dpc_d            = next_pc_i;
               cause_d          = CauseRequest;
               redirect_valid_d = 1'b1;
               redirect_pc_d    = HaltPc;
               debug_mode_d     = 1'b1;
               state_d          = HALTED;
            end
         end
         HALTED: begin
            // A resume arriving while a redirect is on the bus is held for the next cycle.
            if (redirect_valid_q) begin
               resume_pend_d = resume_now;
            end else if (ex_in_debug_i) begin
               redirect_valid_d = 1'b1;
               redirect_pc_d    = ExceptionPc;
               resume_pend_d    = 1'b0;
            end else if (dret_i) begin
               redirect_valid_d = 1'b1;
               redirect_pc_d    = dpc_q;
               debug_mode_d     = 1'b0;
               resume_pend_d    = 1'b0;
               state_d          = step_i ? STEP : RUN;
            end else if (resume_now) begin
               redirect_valid_d = 1'b1;
               redirect_pc_d    = ResumePc;
               resume_pend_d    = 1'b0;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q          <= RUN;
         flush_q          <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         debug_mode_q     <= 1'b0;
         dpc_q            <= '0;
         cause_q          <= '0;
         resume_pend_q    <= 1'b0;
      end else begin
         state_q          <= state_d;
         flush_q          <= flush_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         debug_mode_q     <= debug_mode_d;
         dpc_q            <= dpc_d;
         cause_q          <= cause_d;
         resume_pend_q    <= resume_pend_d;
      end
   end

   assign flush_o          = flush_q;
   assign redirect_valid_o = redirect_valid_q;
   assign redirect_pc_o    = redirect_pc_q;
   assign debug_mode_o     = debug_mode_q;
   assign dpc_o            = dpc_q;
   assign cause_o          = cause_q;

endmodule

// File: tb/tb_ariane_debug_hart_ctrl.sv
// tb/tb_ariane_debug_hart_ctrl.sv - self-checking bench for ariane_debug_hart_ctrl
module tb_ariane_debug_hart_ctrl;

   logic        clk = 1'b0;
   logic        rst_i, debug_req_i, resumereq_i, ebreak_i, trigger_i, commit_valid_i;
   logic [63:0] commit_pc_i, next_pc_i;
   logic        step_i, flush_done_i, dret_i, ex_in_debug_i;
   logic        flush_o, redirect_valid_o, debug_mode_o;
   logic [63:0] redirect_pc_o, dpc_o;
   logic [2:0]  cause_o;

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 1'b0;

   // reference model: what the outputs must show after the latest clock edge
   bit          m_halted, m_flushing, m_stepping, m_resume_pending;
   bit          e_flush, e_redir, e_dm;
   logic [63:0] e_rpc, e_dpc;
   logic [2:0]  e_cause;

   always #5 clk = ~clk;

   ariane_debug_hart_ctrl #(.XLEN(64), .DmBase(64'h0)) dut (
      .clk_i(clk), .rst_i(rst_i), .debug_req_i(debug_req_i), .resumereq_i(resumereq_i),
      .ebreak_i(ebreak_i), .trigger_i(trigger_i), .commit_valid_i(commit_valid_i),
      .commit_pc_i(commit_pc_i), .next_pc_i(next_pc_i), .step_i(step_i),
      .flush_done_i(flush_done_i), .dret_i(dret_i), .ex_in_debug_i(ex_in_debug_i),
      .flush_o(flush_o), .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
      .debug_mode_o(debug_mode_o), .dpc_o(dpc_o), .cause_o(cause_o)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic m_halt(input logic [63:0] pc, input logic [2:0] c);
      e_dpc = pc; e_cause = c; e_redir = 1'b1; e_rpc = 64'h800; e_dm = 1'b1;
      m_halted = 1'b1; m_stepping = 1'b0;
   endtask

   task automatic model_step();
      bit prev_redir, want_resume;
      prev_redir = e_redir;
      e_redir = 1'b0;
      if (rst_i) begin
         m_halted = 0; m_flushing = 0; m_stepping = 0; m_resume_pending = 0;
         e_flush = 0; e_dm = 0; e_rpc = '0; e_dpc = '0; e_cause = '0;
      end else if (m_flushing) begin
         if (flush_done_i) begin
            m_flushing = 0; e_flush = 0;
            m_halt(next_pc_i, 3'd3);
         end
      end else if (!m_halted) begin
         if (commit_valid_i && trigger_i)       m_halt(commit_pc_i, 3'd2);
         else if (commit_valid_i && ebreak_i)   m_halt(commit_pc_i, 3'd1);
         else if (m_stepping && commit_valid_i) m_halt(next_pc_i, 3'd4);
         else if (debug_req_i) begin
            m_flushing = 1; e_flush = 1;
         end
      end else begin
         want_resume = resumereq_i || m_resume_pending;
         if (prev_redir) m_resume_pending = want_resume;
         else if (ex_in_debug_i) begin
            e_redir = 1; e_rpc = 64'h808; m_resume_pending = 0;
         end else if (dret_i) begin
            e_redir = 1; e_rpc = e_dpc; e_dm = 0; m_halted = 0;
            m_stepping = step_i; m_resume_pending = 0;
         end else if (want_resume) begin
            e_redir = 1; e_rpc = 64'h804; m_resume_pending = 0;
         end
      end
   endtask

   task automatic clk_cycle();
      @(posedge clk);
      model_step();
      #2;
   endtask

   task automatic idle_inputs();
      rst_i = 0; debug_req_i = 0; resumereq_i = 0; ebreak_i = 0; trigger_i = 0;
      commit_valid_i = 0; commit_pc_i = '0; next_pc_i = '0; step_i = 0;
      flush_done_i = 0; dret_i = 0; ex_in_debug_i = 0;
   endtask

   bit prev_dut_redir = 1'b0;
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("flush_o", flush_o, e_flush);
         chk("redirect_valid_o", redirect_valid_o, e_redir);
         if (e_redir) chk("redirect_pc_o", redirect_pc_o, e_rpc);
         chk("debug_mode_o", debug_mode_o, e_dm);
         chk("dpc_o", dpc_o, e_dpc);
         chk("cause_o", cause_o, e_cause);
         chk("flush_and_redirect", flush_o & redirect_valid_o, 1'b0);
         chk("redirect_back_to_back", prev_dut_redir & redirect_valid_o, 1'b0);
      end
      prev_dut_redir = redirect_valid_o;
   end

   initial begin
      idle_inputs();
      rst_i = 1;
      clk_cycle(); clk_cycle();
      rst_i = 0;
      cmp_en = 1;
      chk("reset_redirect", redirect_valid_o, 0);
      chk("reset_dm", debug_mode_o, 0);
      chk("reset_dpc", dpc_o, 0);
      clk_cycle();

      // 1: ebreak halt
      commit_valid_i = 1; ebreak_i = 1; commit_pc_i = 64'h8000_0010;
      clk_cycle(); idle_inputs();
      chk("t1_redir", redirect_valid_o, 1);
      chk("t1_rpc", redirect_pc_o, 64'h800);
      chk("t1_dpc", dpc_o, 64'h8000_0010);
      chk("t1_cause", cause_o, 3'd1);
      chk("t1_dm", debug_mode_o, 1);
      chk("t1_model_dpc", e_dpc, 64'h8000_0010);
      clk_cycle();

      // 3: resume then dret
      resumereq_i = 1; clk_cycle(); idle_inputs();
      chk("t3_resume_rpc", redirect_pc_o, 64'h804);
      chk("t3_model_rpc", e_rpc, 64'h804);
      clk_cycle();
      dret_i = 1; clk_cycle(); idle_inputs();
      chk("t3_dret_redir", redirect_valid_o, 1);
      chk("t3_dret_rpc", redirect_pc_o, 64'h8000_0010);
      chk("t3_dret_dm", debug_mode_o, 0);
      clk_cycle();

      // 2: halt request with a 4-cycle flush
      debug_req_i = 1; next_pc_i = 64'h8000_0100;
      clk_cycle(); debug_req_i = 0;
      for (int i = 0; i < 4; i++) begin
         chk("t2_flush_held", flush_o, 1);
         if (i == 3) flush_done_i = 1;
         clk_cycle();
      end
      idle_inputs();
      chk("t2_flush_off", flush_o, 0);
      chk("t2_rpc", redirect_pc_o, 64'h800);
      chk("t2_dpc", dpc_o, 64'h8000_0100);
      chk("t2_cause", cause_o, 3'd3);
      chk("t2_model_cause", e_cause, 3'd3);
      clk_cycle();

      // 4: single step
      dret_i = 1; step_i = 1; clk_cycle(); idle_inputs();
      chk("t4_dret_rpc", redirect_pc_o, 64'h8000_0100);
      clk_cycle();
      commit_valid_i = 1; next_pc_i = 64'h8000_0104; commit_pc_i = 64'h8000_0100;
      clk_cycle(); idle_inputs();
      chk("t4_rpc", redirect_pc_o, 64'h800);
      chk("t4_dpc", dpc_o, 64'h8000_0104);
      chk("t4_cause", cause_o, 3'd4);
      chk("t4_dm", debug_mode_o, 1);
      clk_cycle();

      // 5: priority and exception in debug mode
      dret_i = 1; clk_cycle(); idle_inputs(); clk_cycle();
      trigger_i = 1; ebreak_i = 1; debug_req_i = 1; commit_valid_i = 1; commit_pc_i = 64'h8000_0200;
      clk_cycle(); idle_inputs();
      chk("t5_cause", cause_o, 3'd2);
      chk("t5_no_flush", flush_o, 0);
      chk("t5_dpc", dpc_o, 64'h8000_0200);
      clk_cycle();
      ex_in_debug_i = 1; clk_cycle(); idle_inputs();
      chk("t5_ex_rpc", redirect_pc_o, 64'h808);
      chk("t5_ex_cause", cause_o, 3'd2);
      clk_cycle();

      // 6: reset during flush
      dret_i = 1; clk_cycle(); idle_inputs(); clk_cycle();
      debug_req_i = 1; clk_cycle(); debug_req_i = 0;
      chk("t6_flush", flush_o, 1);
      rst_i = 1; clk_cycle(); rst_i = 0;
      chk("t6_rst_flush", flush_o, 0);
      chk("t6_rst_dpc", dpc_o, 0);
      clk_cycle();
      chk("t6_no_redirect", redirect_valid_o, 0);
      commit_valid_i = 1; ebreak_i = 1; commit_pc_i = 64'h8000_0300;
      clk_cycle(); idle_inputs();
      chk("t6_halt_dpc", dpc_o, 64'h8000_0300);
      chk("t6_halt_cause", cause_o, 3'd1);
      clk_cycle();
      dret_i = 1; clk_cycle(); idle_inputs(); clk_cycle();

      // randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         rst_i          = ($urandom_range(0, 299) == 0);
         debug_req_i    = ($urandom_range(0, 7) == 0);
         resumereq_i    = ($urandom_range(0, 9) == 0);
         step_i         = 1'($urandom_range(0, 1));
         commit_valid_i = !e_redir && ($urandom_range(0, 2) == 0);
         ebreak_i       = ($urandom_range(0, 5) == 0);
         trigger_i      = ($urandom_range(0, 7) == 0);
         commit_pc_i    = {$urandom, $urandom};
         next_pc_i      = {$urandom, $urandom};
         dret_i         = m_halted && !e_redir && ($urandom_range(0, 5) == 0);
         ex_in_debug_i  = m_halted && !e_redir && ($urandom_range(0, 9) == 0);
         flush_done_i   = m_flushing && ($urandom_range(0, 2) == 0);
         clk_cycle();
      end
      idle_inputs();
      clk_cycle();
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
